// File: rtl/hazard_pkg.sv
// Shared encodings for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MEMWAIT = 2'd1,
        ST_FLUSH   = 2'd2
    } state_t;

    // MIPS $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Wait counter is wide enough for the largest legal timeout.
    localparam int WAIT_W = 16;

    // Flush counter holds at most BR_PENALTY-1 = 3.
    localparam int FLUSH_W = 3;

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear and parallel load.
// Priority: reset > clear > load > increment.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    localparam logic [W-1:0] CNT_MAX = '1;

    // Count register; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            cnt_o <= '0;
        end else if (load_i) begin
            cnt_o <= load_val_i;
        end else if (inc_i && (cnt_o != CNT_MAX)) begin
            cnt_o <= cnt_o + W'(1);
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage MIPS core: drives the
// pipeline register enables and flush/bubble controls, resolves load-use,
// taken-branch and data-memory wait hazards, counts stall cycles and flags
// memory timeouts.
//
// state   | meaning
// --------+-----------------------------------------------------------
// RUN     | normal issue; load-use stalls are resolved in place
// MEMWAIT | data access outstanding, whole pipeline frozen
// FLUSH   | extra branch-penalty cycles, IF/ID loads NOPs
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int BR_PENALTY  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs_i,
    input  logic [4:0]       ifid_rt_i,
    input  logic             ifid_uses_rt_i,
    input  logic [4:0]       idex_rt_i,
    input  logic             idex_memread_i,
    input  logic             branch_taken_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_en_o,
    output logic             ifid_en_o,
    output logic             idex_en_o,
    output logic             exmem_en_o,
    output logic             memwb_en_o,
    output logic             ifid_flush_o,
    output logic             idex_bubble_o,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic             err_o
);

    localparam int                 WAIT_X     = WAIT_W + 1;
    localparam logic [FLUSH_W-1:0] BR_RELOAD  = FLUSH_W'(BR_PENALTY - 1);
    localparam logic [WAIT_X-1:0]  TIMEOUT_TC = WAIT_X'(MEM_TIMEOUT);

    state_t               state_q;
    state_t               state_d;

    logic                 mem_stall;
    logic                 load_use;
    logic                 run_eval;

    logic [WAIT_W-1:0]    wait_cnt;
    logic                 wait_inc;
    logic                 wait_load;
    logic                 wait_clear;
    logic [WAIT_X-1:0]    wait_next;

    logic [FLUSH_W-1:0]   flush_cnt;
    logic                 flush_load;
    logic                 flush_clear;
    logic [FLUSH_W-1:0]   flush_load_val;

    assign mem_stall = dmem_req_i & ~dmem_ready_i;
    assign load_use  = idex_memread_i & (idex_rt_i != REG_ZERO) &
                       ((idex_rt_i == ifid_rs_i) |
                        (ifid_uses_rt_i & (idex_rt_i == ifid_rt_i)));

    assign state_o = state_q;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, Mealy enables and counter controls. MEMWAIT exit reuses
    // the RUN decision so a ready cycle is never lost.
    always_comb begin
        state_d        = state_q;
        pc_en_o        = 1'b1;
        ifid_en_o      = 1'b1;
        idex_en_o      = 1'b1;
        exmem_en_o     = 1'b1;
        memwb_en_o     = 1'b1;
        ifid_flush_o   = 1'b0;
        idex_bubble_o  = 1'b0;
        wait_inc       = 1'b0;
        wait_load      = 1'b0;
        wait_clear     = 1'b0;
        flush_load     = 1'b0;
        flush_clear    = 1'b0;
        flush_load_val = '0;
        run_eval       = 1'b0;

        case (state_q)
            ST_RUN: begin
                run_eval = 1'b1;
            end
            ST_MEMWAIT: begin
                if (mem_stall) begin
                    pc_en_o    = 1'b0;
                    ifid_en_o  = 1'b0;
                    idex_en_o  = 1'b0;
                    exmem_en_o = 1'b0;
                    memwb_en_o = 1'b0;
                    wait_inc   = 1'b1;
                end else begin
                    wait_clear = 1'b1;
                    run_eval   = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (mem_stall) begin
                    pc_en_o    = 1'b0;
                    ifid_en_o  = 1'b0;
                    idex_en_o  = 1'b0;
                    exmem_en_o = 1'b0;
                    memwb_en_o = 1'b0;
                end else if (branch_taken_i) begin
                    ifid_flush_o  = 1'b1;
                    idex_bubble_o = 1'b1;
                    if (BR_PENALTY > 1) begin
                        flush_load     = 1'b1;
                        flush_load_val = BR_RELOAD;
                    end else begin
                        flush_clear = 1'b1;
                        state_d     = ST_RUN;
                    end
                end else begin
                    ifid_flush_o = 1'b1;
                    if (flush_cnt <= FLUSH_W'(1)) begin
                        flush_clear = 1'b1;
                        state_d     = ST_RUN;
                    end else begin
                        flush_load     = 1'b1;
                        flush_load_val = flush_cnt - FLUSH_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if (run_eval) begin
            if (mem_stall) begin
                pc_en_o    = 1'b0;
                ifid_en_o  = 1'b0;
                idex_en_o  = 1'b0;
                exmem_en_o = 1'b0;
                memwb_en_o = 1'b0;
                wait_load  = 1'b1;
                state_d    = ST_MEMWAIT;
            end else if (branch_taken_i) begin
                // The ID instruction is squashed, so any load-use is moot.
                ifid_flush_o  = 1'b1;
                idex_bubble_o = 1'b1;
                if (BR_PENALTY > 1) begin
                    flush_load     = 1'b1;
                    flush_load_val = BR_RELOAD;
                    state_d        = ST_FLUSH;
                end else begin
                    state_d = ST_RUN;
                end
            end else if (load_use) begin
                pc_en_o       = 1'b0;
                ifid_en_o     = 1'b0;
                idex_bubble_o = 1'b1;
                state_d       = ST_RUN;
            end else begin
                state_d = ST_RUN;
            end
        end

        if (rst_i) begin
            pc_en_o       = 1'b0;
            ifid_en_o     = 1'b0;
            idex_en_o     = 1'b0;
            exmem_en_o    = 1'b0;
            memwb_en_o    = 1'b0;
            ifid_flush_o  = 1'b1;
            idex_bubble_o = 1'b1;
        end
    end

    // Value the wait counter takes at this edge, one bit wider so the
    // timeout compare still works when the counter saturates.
    assign wait_next = wait_load ? WAIT_X'(1) : ({1'b0, wait_cnt} + WAIT_X'(1));

    // Sticky timeout flag; set on the edge the wait count reaches the limit.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_o <= 1'b0;
        end else if ((wait_load || wait_inc) && (wait_next >= TIMEOUT_TC)) begin
            err_o <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (1'b0),
        .load_i     (1'b0),
        .load_val_i ({CNT_W{1'b0}}),
        .inc_i      (~pc_en_o & ~rst_i),
        .cnt_o      (stall_cnt_o)
    );

    sat_counter #(.W(WAIT_W)) u_wait_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (wait_clear),
        .load_i     (wait_load),
        .load_val_i (WAIT_W'(1)),
        .inc_i      (wait_inc),
        .cnt_o      (wait_cnt)
    );

    sat_counter #(.W(FLUSH_W)) u_flush_cnt (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .clear_i    (flush_clear),
        .load_i     (flush_load),
        .load_val_i (flush_load_val),
        .inc_i      (1'b0),
        .cnt_o      (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl with BR_PENALTY=2 and MEM_TIMEOUT=4.
module tb_hazard_ctrl;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [4:0]  ifid_rs_i;
    logic [4:0]  ifid_rt_i;
    logic        ifid_uses_rt_i;
    logic [4:0]  idex_rt_i;
    logic        idex_memread_i;
    logic        branch_taken_i;
    logic        dmem_req_i;
    logic        dmem_ready_i;
    logic        pc_en_o;
    logic        ifid_en_o;
    logic        idex_en_o;
    logic        exmem_en_o;
    logic        memwb_en_o;
    logic        ifid_flush_o;
    logic        idex_bubble_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic        err_o;

    logic [4:0]  ens;
    int          errors = 0;
    int          checks = 0;

    assign ens = {pc_en_o, ifid_en_o, idex_en_o, exmem_en_o, memwb_en_o};

    hazard_ctrl #(
        .BR_PENALTY  (2),
        .MEM_TIMEOUT (4),
        .CNT_W       (16)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ifid_rs_i      (ifid_rs_i),
        .ifid_rt_i      (ifid_rt_i),
        .ifid_uses_rt_i (ifid_uses_rt_i),
        .idex_rt_i      (idex_rt_i),
        .idex_memread_i (idex_memread_i),
        .branch_taken_i (branch_taken_i),
        .dmem_req_i     (dmem_req_i),
        .dmem_ready_i   (dmem_ready_i),
        .pc_en_o        (pc_en_o),
        .ifid_en_o      (ifid_en_o),
        .idex_en_o      (idex_en_o),
        .exmem_en_o     (exmem_en_o),
        .memwb_en_o     (memwb_en_o),
        .ifid_flush_o   (ifid_flush_o),
        .idex_bubble_o  (idex_bubble_o),
        .state_o        (state_o),
        .stall_cnt_o    (stall_cnt_o),
        .err_o          (err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic idle();
        ifid_rs_i      = 5'd0;
        ifid_rt_i      = 5'd0;
        ifid_uses_rt_i = 1'b0;
        idex_rt_i      = 5'd0;
        idex_memread_i = 1'b0;
        branch_taken_i = 1'b0;
        dmem_req_i     = 1'b0;
        dmem_ready_i   = 1'b0;
    endtask

    // Advance one edge and land 1 time unit after it.
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        rst_i = 1'b1;
        idle();
        tick();
        rst_i = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        #1;
        checks++;
        if (ens !== 5'b00000 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_outputs: ens=%b flush=%b bubble=%b, want 00000 1 1", ens, ifid_flush_o, idex_bubble_o);
        end
        tick();
        rst_i = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd0 || stall_cnt_o !== 16'd0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d stall=%0d err=%b, want 0 0 0", state_o, stall_cnt_o, err_o);
        end
        checks++;
        if (ens !== 5'b11111 || ifid_flush_o !== 1'b0 || idex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL run_idle: ens=%b flush=%b bubble=%b, want 11111 0 0", ens, ifid_flush_o, idex_bubble_o);
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd8;
        ifid_rs_i      = 5'd8;
        #1;
        checks++;
        if (ens !== 5'b00111 || idex_bubble_o !== 1'b1 || ifid_flush_o !== 1'b0) begin
            errors++;
            $display("FAIL load_use_rs: ens=%b bubble=%b flush=%b, want 00111 1 0", ens, idex_bubble_o, ifid_flush_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (stall_cnt_o !== 16'd1 || state_o !== 2'd0 || pc_en_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use_after: stall=%0d state=%0d pc_en=%b, want 1 0 1", stall_cnt_o, state_o, pc_en_o);
        end
        idex_memread_i = 1'b1;
        #1;
        checks++;
        if (pc_en_o !== 1'b1 || idex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL load_use_r0: pc_en=%b bubble=%b, want 1 0", pc_en_o, idex_bubble_o);
        end
        idex_rt_i      = 5'd9;
        ifid_rs_i      = 5'd3;
        ifid_rt_i      = 5'd9;
        ifid_uses_rt_i = 1'b1;
        #1;
        checks++;
        if (pc_en_o !== 1'b0 || idex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL load_use_rt: pc_en=%b bubble=%b, want 0 1", pc_en_o, idex_bubble_o);
        end
        ifid_uses_rt_i = 1'b0;
        #1;
        checks++;
        if (pc_en_o !== 1'b1 || idex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL load_use_rt_unused: pc_en=%b bubble=%b, want 1 0", pc_en_o, idex_bubble_o);
        end
        idle();
        tick();
    endtask

    task automatic test_branch();
        apply_reset();
        branch_taken_i = 1'b1;
        #1;
        checks++;
        if (ens !== 5'b11111 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b1 || state_o !== 2'd0) begin
            errors++;
            $display("FAIL branch_c1: ens=%b flush=%b bubble=%b state=%0d, want 11111 1 1 0", ens, ifid_flush_o, idex_bubble_o, state_o);
        end
        tick();
        branch_taken_i = 1'b0;
        #1;
        checks++;
        if (ens !== 5'b11111 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b0 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL branch_c2: ens=%b flush=%b bubble=%b state=%0d, want 11111 1 0 2", ens, ifid_flush_o, idex_bubble_o, state_o);
        end
        tick();
        checks++;
        if (state_o !== 2'd0 || ifid_flush_o !== 1'b0 || pc_en_o !== 1'b1 || stall_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL branch_end: state=%0d flush=%b pc_en=%b stall=%0d, want 0 0 1 0", state_o, ifid_flush_o, pc_en_o, stall_cnt_o);
        end
    endtask

    task automatic test_memwait();
        apply_reset();
        dmem_req_i   = 1'b1;
        dmem_ready_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if (ens !== 5'b00000 || ifid_flush_o !== 1'b0 || state_o !== ((i == 0) ? 2'd0 : 2'd1)) begin
                errors++;
                $display("FAIL memwait_c%0d: ens=%b flush=%b state=%0d", i, ens, ifid_flush_o, state_o);
            end
            tick();
        end
        dmem_ready_i = 1'b1;
        #1;
        checks++;
        if (ens !== 5'b11111 || state_o !== 2'd1 || stall_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL memwait_ready: ens=%b state=%0d stall=%0d, want 11111 1 5", ens, state_o, stall_cnt_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (state_o !== 2'd0 || stall_cnt_o !== 16'd5) begin
            errors++;
            $display("FAIL memwait_exit: state=%0d stall=%0d, want 0 5", state_o, stall_cnt_o);
        end
    endtask

    task automatic test_timeout();
        apply_reset();
        dmem_req_i   = 1'b1;
        dmem_ready_i = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (err_o !== ((k >= 4) ? 1'b1 : 1'b0) || state_o !== 2'd1) begin
                errors++;
                $display("FAIL timeout_w%0d: err=%b state=%0d, want err=%b state=1", k, err_o, state_o, (k >= 4));
            end
        end
        dmem_ready_i = 1'b1;
        tick();
        idle();
        tick();
        checks++;
        if (err_o !== 1'b1 || state_o !== 2'd0 || stall_cnt_o !== 16'd6) begin
            errors++;
            $display("FAIL timeout_sticky: err=%b state=%0d stall=%0d, want 1 0 6", err_o, state_o, stall_cnt_o);
        end
        apply_reset();
        checks++;
        if (err_o !== 1'b0) begin
            errors++;
            $display("FAIL timeout_clear: err=%b, want 0", err_o);
        end
    endtask

    task automatic test_flush_events();
        apply_reset();
        branch_taken_i = 1'b1;
        tick();
        branch_taken_i = 1'b0;
        dmem_req_i     = 1'b1;
        #1;
        checks++;
        if (ens !== 5'b00000 || state_o !== 2'd2) begin
            errors++;
            $display("FAIL flush_memstall: ens=%b state=%0d, want 00000 2", ens, state_o);
        end
        tick();
        dmem_req_i     = 1'b0;
        branch_taken_i = 1'b1;
        #1;
        checks++;
        if (state_o !== 2'd2 || ens !== 5'b11111 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_rebranch: state=%0d ens=%b flush=%b bubble=%b, want 2 11111 1 1", state_o, ens, ifid_flush_o, idex_bubble_o);
        end
        tick();
        branch_taken_i = 1'b0;
        #1;
        checks++;
        if (state_o !== 2'd2 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL flush_reload: state=%0d flush=%b bubble=%b, want 2 1 0", state_o, ifid_flush_o, idex_bubble_o);
        end
        tick();
        checks++;
        if (state_o !== 2'd0 || stall_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL flush_exit: state=%0d stall=%0d, want 0 1", state_o, stall_cnt_o);
        end
    endtask

    task automatic test_simultaneous();
        apply_reset();
        branch_taken_i = 1'b1;
        idex_memread_i = 1'b1;
        idex_rt_i      = 5'd8;
        ifid_rs_i      = 5'd8;
        #1;
        checks++;
        if (ens !== 5'b11111 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL br_loaduse: ens=%b flush=%b bubble=%b, want 11111 1 1", ens, ifid_flush_o, idex_bubble_o);
        end
        tick();
        idle();
        tick();
        branch_taken_i = 1'b1;
        dmem_req_i     = 1'b1;
        #1;
        checks++;
        if (state_o !== 2'd0 || ens !== 5'b00000 || ifid_flush_o !== 1'b0 || idex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL br_memstall: state=%0d ens=%b flush=%b bubble=%b, want 0 00000 0 0", state_o, ens, ifid_flush_o, idex_bubble_o);
        end
        tick();
        tick();
        dmem_ready_i = 1'b1;
        #1;
        checks++;
        if (state_o !== 2'd1 || ens !== 5'b11111 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b1) begin
            errors++;
            $display("FAIL br_on_ready: state=%0d ens=%b flush=%b bubble=%b, want 1 11111 1 1", state_o, ens, ifid_flush_o, idex_bubble_o);
        end
        tick();
        idle();
        #1;
        checks++;
        if (state_o !== 2'd2 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b0) begin
            errors++;
            $display("FAIL br_after_ready: state=%0d flush=%b bubble=%b, want 2 1 0", state_o, ifid_flush_o, idex_bubble_o);
        end
        tick();
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        dmem_req_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b1;
        #1;
        checks++;
        if (ens !== 5'b00000 || ifid_flush_o !== 1'b1 || idex_bubble_o !== 1'b1 || state_o !== 2'd1) begin
            errors++;
            $display("FAIL rst_mid_comb: ens=%b flush=%b bubble=%b state=%0d, want 00000 1 1 1", ens, ifid_flush_o, idex_bubble_o, state_o);
        end
        tick();
        rst_i = 1'b0;
        idle();
        #1;
        checks++;
        if (state_o !== 2'd0 || stall_cnt_o !== 16'd0 || err_o !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_after: state=%0d stall=%0d err=%b, want 0 0 0", state_o, stall_cnt_o, err_o);
        end
    endtask

    initial begin
        rst_i = 1'b1;
        idle();
        tick();
        test_reset();
        test_load_use();
        test_branch();
        test_memwait();
        test_timeout();
        test_flush_events();
        test_simultaneous();
        test_reset_mid_wait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline sequencing controller for the 5-stage MIPS core. It drives the write enables of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, and it drives the flush/bubble controls. It resolves load-use hazards, taken-branch squashes and data-memory wait states, and it keeps a stall-cycle performance counter and a memory-timeout error flag.

Parameters:
BR_PENALTY, 1, cycles IF/ID is flushed after a taken branch (legal range 1..4)
MEM_TIMEOUT, 255, maximum consecutive wait cycles before err_o sets (legal range 1..65535)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk_i  in  1  clock; all state updates on the rising edge
rst_i  in  1  synchronous reset, active-high
ifid_rs_i  in  5  rs field of the instruction in ID
ifid_rt_i  in  5  rt field of the instruction in ID
ifid_uses_rt_i  in  1  ID instruction reads rt as a source
idex_rt_i  in  5  rt (destination) of the instruction in EX
idex_memread_i  in  1  instruction in EX is a load
branch_taken_i  in  1  branch/jump resolved taken in EX
dmem_req_i  in  1  MEM stage has an active data access
dmem_ready_i  in  1  data memory completes the access this cycle
pc_en_o  out  1  PC write enable
ifid_en_o  out  1  IF/ID write enable
idex_en_o  out  1  ID/EX write enable
exmem_en_o  out  1  EX/MEM write enable
memwb_en_o  out  1  MEM/WB write enable
ifid_flush_o  out  1  IF/ID loads a NOP
idex_bubble_o  out  1  ID/EX loads all-zero control signals
state_o  out  2  FSM state: RUN=0, MEMWAIT=1, FLUSH=2
stall_cnt_o  out  CNT_W  saturating count of cycles with pc_en_o=0
err_o  out  1  sticky memory-timeout error

Behaviour:
- Clock is clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state RUN, flush counter 0, wait counter 0, stall_cnt_o 0, err_o 0.
- While rst_i=1: all *_en_o=0, ifid_flush_o=1, idex_bubble_o=1.
- Enable and flush outputs are combinational (Mealy) from the current state and the inputs. state_o, the counters and err_o are registered.
- Hazard terms:
  - mem_stall = dmem_req_i & ~dmem_ready_i.
  - load_use = idex_memread_i & (idex_rt_i!=0) & ((idex_rt_i==ifid_rs_i) | (ifid_uses_rt_i & (idex_rt_i==ifid_rt_i))).
- Priority, in every state: mem_stall > branch/flush > load_use.
- RUN:
  - mem_stall: all five enables 0, no flush or bubble. Next state MEMWAIT, wait counter set to 1.
  - else branch_taken_i: all enables 1, ifid_flush_o=1, idex_bubble_o=1. Next state FLUSH if BR_PENALTY>1 (flush counter = BR_PENALTY-1), else RUN. Any simultaneous load_use is ignored because the ID instruction is squashed.
  - else load_use: pc_en_o=0, ifid_en_o=0, idex_en_o=1, idex_bubble_o=1, exmem_en_o=1, memwb_en_o=1. Stays RUN; the hazard clears itself after one cycle as the load advances.
  - else: all enables 1, no flush or bubble.
- MEMWAIT:
  - All enables 0 while mem_stall holds. A branch_taken_i that is present is held by the frozen EX stage and evaluated on exit.
  - Wait counter increments each cycle (saturating). When it reaches MEM_TIMEOUT, err_o sets and stays 1 until reset; the FSM keeps waiting.
  - On dmem_ready_i: evaluate exactly as RUN with mem_stall=0 in the same cycle (no lost cycle). Next state is whatever RUN would choose. Wait counter clears.
- FLUSH:
  - All enables 1, ifid_flush_o=1, idex_bubble_o=0. Flush counter decrements; at 1, next state is RUN.
  - mem_stall in FLUSH: enables 0, flush counter holds, stay FLUSH.
  - A new branch_taken_i in FLUSH reloads the counter to BR_PENALTY-1 and asserts idex_bubble_o.
- stall_cnt_o increments in each cycle where rst_i=0 and pc_en_o=0. It saturates at 2^CNT_W-1.
- Reset asserted in any state, including mid-MEMWAIT, returns to the reset values on the next edge.

Decomposition:
- Shared package hazard_pkg: state encodings RUN/MEMWAIT/FLUSH and the register-0 constant 5'd0.
- One natural sub-module: sat_counter (parameterised width, inc/clear/load, saturating). It is instantiated for stall_cnt_o, the wait counter and the flush counter.
- Hazard comparators stay inline.

Test Plan:
1. Load-use: idex_memread_i=1, idex_rt_i=8, ifid_rs_i=8 for one cycle -> pc_en_o=0, ifid_en_o=0, idex_bubble_o=1 that cycle; stall_cnt_o=1 next cycle; rt=0 with rs=0 -> no stall.
2. Taken branch with BR_PENALTY=2: branch_taken_i pulse -> ifid_flush_o=1 for 2 cycles, idex_bubble_o=1 only in the first cycle, state_o RUN->FLUSH->RUN, pc_en_o=1 throughout.
3. Memory wait: dmem_req_i=1, dmem_ready_i=0 for 5 cycles then ready=1 -> all enables 0 for 5 cycles, 1 in the ready cycle; stall_cnt_o=5; state_o=1 during the wait.
4. Timeout with MEM_TIMEOUT=4: hold mem_stall for 6 cycles -> err_o=1 from the 4th wait cycle onward; err_o stays 1 after ready; clears only on rst_i.
5. Simultaneous events: branch_taken_i and load_use together -> flush and bubble with pc_en_o=1; mem_stall together with branch -> enables 0, then on ready the flush occurs in the same cycle.
6. Reset mid-MEMWAIT: rst_i=1 for 1 cycle -> enables 0, flush 1 during reset; state_o=0, stall_cnt_o=0, err_o=0 after the edge.
